// File: rtl/alu_reservation_station_pkg.sv
// Shared sizing, entry layout and helpers for the ALU reservation station.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_reservation_station_pkg;

    localparam int RS_SIZE   = 16;
    localparam int RS_ID_WID = $clog2(RS_SIZE);
    localparam int ROB_ID_W  = 4;
    localparam int DATA_W    = 32;
    localparam int OPCODE_W  = 7;
    localparam int FUNC3_W   = 3;
    localparam int CNT_W     = RS_ID_WID + 1;

    // One buffered op. rN=1 means vN holds the operand value;
    // rN=0 means the operand is still owed by ROB tag qN.
    typedef struct packed {
        logic                busy;
        logic [OPCODE_W-1:0] opcode;
        logic [FUNC3_W-1:0]  func3;
        logic                func1;
        logic                r1;
        logic [ROB_ID_W-1:0] q1;
        logic [DATA_W-1:0]   v1;
        logic                r2;
        logic [ROB_ID_W-1:0] q2;
        logic [DATA_W-1:0]   v2;
        logic [DATA_W-1:0]   imm;
        logic [DATA_W-1:0]   off;
        logic [DATA_W-1:0]   pc;
        logic [ROB_ID_W-1:0] rob_target;
        logic                is_c;
    } rs_entry_t;

    function automatic logic [CNT_W-1:0] count_busy(input logic [RS_SIZE-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/alu_reservation_station_prio_enc.sv
// Lowest-set-bit encoder: returns index of the lowest 1 in vec and whether any bit is set.
// Latency: purely combinational.
// Backpressure: none.
// Ports: vec (N bits) in; idx (W bits) out, found out.
module alu_reservation_station_prio_enc #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scanning high-to-low lets the last hit (lowest index) win.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Tomasulo reservation station for the integer ALU: buffers dispatched ops, snoops ALU/LSB CDBs, issues one ready op per cycle.
// Latency: fully-ready dispatch -> iss_valid one cycle after the dispatch edge; CDB wake-up at edge N -> issuable at edge N+1.
// Backpressure: registered full with one slack entry; rdy=0 freezes everything; dispatch with no free slot is dropped.
// Ports: clk, rst (sync, active-high), rdy, rollback; disp_* dispatch bundle from decoder;
//        alu_cdb_* / lsb_cdb_* broadcast buses; full to decoder; iss_* operand bus to the ALU.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,

    input  logic                disp_valid,
    input  logic [OPCODE_W-1:0] disp_opcode,
    input  logic [FUNC3_W-1:0]  disp_func3,
    input  logic                disp_func1,
    input  logic                disp_rs1_rdy,
    input  logic [DATA_W-1:0]   disp_rs1_val,
    input  logic [ROB_ID_W-1:0] disp_rs1_dep,
    input  logic                disp_rs2_rdy,
    input  logic [DATA_W-1:0]   disp_rs2_val,
    input  logic [ROB_ID_W-1:0] disp_rs2_dep,
    input  logic [DATA_W-1:0]   disp_imm,
    input  logic [DATA_W-1:0]   disp_off,
    input  logic [DATA_W-1:0]   disp_pc,
    input  logic [ROB_ID_W-1:0] disp_rob_target,
    input  logic                disp_is_c,

    input  logic                alu_cdb_valid,
    input  logic [ROB_ID_W-1:0] alu_cdb_tag,
    input  logic [DATA_W-1:0]   alu_cdb_data,
    input  logic                lsb_cdb_valid,
    input  logic [ROB_ID_W-1:0] lsb_cdb_tag,
    input  logic [DATA_W-1:0]   lsb_cdb_data,

    output logic                full,
    output logic                iss_valid,
    output logic [OPCODE_W-1:0] iss_opcode,
    output logic [FUNC3_W-1:0]  iss_func3,
    output logic                iss_func1,
    output logic [DATA_W-1:0]   iss_data1,
    output logic [DATA_W-1:0]   iss_data2,
    output logic [DATA_W-1:0]   iss_imm,
    output logic [DATA_W-1:0]   iss_off,
    output logic [DATA_W-1:0]   iss_pc,
    output logic [ROB_ID_W-1:0] iss_rob_target,
    output logic                iss_is_c
);

    rs_entry_t ent     [RS_SIZE];
    rs_entry_t ent_nxt [RS_SIZE];
    rs_entry_t disp_ent;

    logic [RS_SIZE-1:0]   ready_vec;
    logic [RS_SIZE-1:0]   free_vec;
    logic [RS_SIZE-1:0]   busy_nxt;
    logic [RS_ID_WID-1:0] iss_idx;
    logic [RS_ID_WID-1:0] free_idx;
    logic                 iss_found;
    logic                 free_found;
    logic                 iss_fire;
    logic                 disp_fire;
    logic [CNT_W-1:0]     cnt_nxt;

    // Selection works on the state at the start of the cycle, so an
    // operand woken this cycle only becomes issuable next cycle.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = ent[i].busy && ent[i].r1 && ent[i].r2;
        end
    end

    alu_reservation_station_prio_enc #(.N(RS_SIZE), .W(RS_ID_WID)) u_ready_sel (
        .vec   (ready_vec),
        .idx   (iss_idx),
        .found (iss_found)
    );

    assign iss_fire = rdy && iss_found;

    // The slot being issued counts as free so dispatch can reuse it this cycle.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i] = !ent[i].busy || (iss_fire && (iss_idx == RS_ID_WID'(i)));
        end
    end

    alu_reservation_station_prio_enc #(.N(RS_SIZE), .W(RS_ID_WID)) u_free_sel (
        .vec   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    assign disp_fire = rdy && disp_valid && free_found;

    // Build the incoming entry; a producer broadcasting in the dispatch
    // cycle is caught here since the stored tag would miss it.
    always_comb begin
        disp_ent            = '0;
        disp_ent.busy       = 1'b1;
        disp_ent.opcode     = disp_opcode;
        disp_ent.func3      = disp_func3;
        disp_ent.func1      = disp_func1;
        disp_ent.imm        = disp_imm;
        disp_ent.off        = disp_off;
        disp_ent.pc         = disp_pc;
        disp_ent.rob_target = disp_rob_target;
        disp_ent.is_c       = disp_is_c;

        if (disp_rs1_rdy) begin
            disp_ent.r1 = 1'b1;
            disp_ent.v1 = disp_rs1_val;
        end else if (alu_cdb_valid && (alu_cdb_tag == disp_rs1_dep)) begin
            disp_ent.r1 = 1'b1;
            disp_ent.v1 = alu_cdb_data;
        end else if (lsb_cdb_valid && (lsb_cdb_tag == disp_rs1_dep)) begin
            disp_ent.r1 = 1'b1;
            disp_ent.v1 = lsb_cdb_data;
        end else begin
            disp_ent.q1 = disp_rs1_dep;
        end

        if (disp_rs2_rdy) begin
            disp_ent.r2 = 1'b1;
            disp_ent.v2 = disp_rs2_val;
        end else if (alu_cdb_valid && (alu_cdb_tag == disp_rs2_dep)) begin
            disp_ent.r2 = 1'b1;
            disp_ent.v2 = alu_cdb_data;
        end else if (lsb_cdb_valid && (lsb_cdb_tag == disp_rs2_dep)) begin
            disp_ent.r2 = 1'b1;
            disp_ent.v2 = lsb_cdb_data;
        end else begin
            disp_ent.q2 = disp_rs2_dep;
        end
    end

    // Next-state: wake-up, then free the issued slot, then allocate.
    // Only pending operands compare tags; captured values are never replaced.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_nxt[i] = ent[i];
            if (ent[i].busy && !ent[i].r1) begin
                if (alu_cdb_valid && (alu_cdb_tag == ent[i].q1)) begin
                    ent_nxt[i].r1 = 1'b1;
                    ent_nxt[i].v1 = alu_cdb_data;
                end else if (lsb_cdb_valid && (lsb_cdb_tag == ent[i].q1)) begin
                    ent_nxt[i].r1 = 1'b1;
                    ent_nxt[i].v1 = lsb_cdb_data;
                end
            end
            if (ent[i].busy && !ent[i].r2) begin
                if (alu_cdb_valid && (alu_cdb_tag == ent[i].q2)) begin
                    ent_nxt[i].r2 = 1'b1;
                    ent_nxt[i].v2 = alu_cdb_data;
                end else if (lsb_cdb_valid && (lsb_cdb_tag == ent[i].q2)) begin
                    ent_nxt[i].r2 = 1'b1;
                    ent_nxt[i].v2 = lsb_cdb_data;
                end
            end
        end
        if (iss_fire) begin
            ent_nxt[iss_idx].busy = 1'b0;
        end
        if (disp_fire) begin
            ent_nxt[free_idx] = disp_ent;
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_nxt[i] = ent_nxt[i].busy;
        end
    end

    assign cnt_nxt = count_busy(busy_nxt);

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
            full           <= 1'b0;
            iss_valid      <= 1'b0;
            iss_opcode     <= '0;
            iss_func3      <= '0;
            iss_func1      <= 1'b0;
            iss_data1      <= '0;
            iss_data2      <= '0;
            iss_imm        <= '0;
            iss_off        <= '0;
            iss_pc         <= '0;
            iss_rob_target <= '0;
            iss_is_c       <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= ent_nxt[i];
            end
            // One entry of slack covers the dispatch already in flight
            // in the cycle full is first seen by the decoder.
            full      <= (cnt_nxt >= CNT_W'(RS_SIZE - 1));
            iss_valid <= iss_fire;
            if (iss_fire) begin
                iss_opcode     <= ent[iss_idx].opcode;
                iss_func3      <= ent[iss_idx].func3;
                iss_func1      <= ent[iss_idx].func1;
                iss_data1      <= ent[iss_idx].v1;
                iss_data2      <= ent[iss_idx].v2;
                iss_imm        <= ent[iss_idx].imm;
                iss_off        <= ent[iss_idx].off;
                iss_pc         <= ent[iss_idx].pc;
                iss_rob_target <= ent[iss_idx].rob_target;
                iss_is_c       <= ent[iss_idx].is_c;
            end
        end
    end

    // The decoder must honour full; an accepted strobe with no room is a protocol error.
    dispatch_has_room: assert property (@(posedge clk) disable iff (rst || rollback)
        (rdy && disp_valid) |-> free_found)
        else $error("alu_reservation_station: dispatch with no free entry");

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        disp_valid;
    logic [6:0]  disp_opcode;
    logic [2:0]  disp_func3;
    logic        disp_func1;
    logic        disp_rs1_rdy;
    logic [31:0] disp_rs1_val;
    logic [3:0]  disp_rs1_dep;
    logic        disp_rs2_rdy;
    logic [31:0] disp_rs2_val;
    logic [3:0]  disp_rs2_dep;
    logic [31:0] disp_imm;
    logic [31:0] disp_off;
    logic [31:0] disp_pc;
    logic [3:0]  disp_rob_target;
    logic        disp_is_c;
    logic        alu_cdb_valid;
    logic [3:0]  alu_cdb_tag;
    logic [31:0] alu_cdb_data;
    logic        lsb_cdb_valid;
    logic [3:0]  lsb_cdb_tag;
    logic [31:0] lsb_cdb_data;
    logic        full;
    logic        iss_valid;
    logic [6:0]  iss_opcode;
    logic [2:0]  iss_func3;
    logic        iss_func1;
    logic [31:0] iss_data1;
    logic [31:0] iss_data2;
    logic [31:0] iss_imm;
    logic [31:0] iss_off;
    logic [31:0] iss_pc;
    logic [3:0]  iss_rob_target;
    logic        iss_is_c;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_func3(disp_func3),
        .disp_func1(disp_func1),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs1_dep(disp_rs1_dep),
        .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val), .disp_rs2_dep(disp_rs2_dep),
        .disp_imm(disp_imm), .disp_off(disp_off), .disp_pc(disp_pc),
        .disp_rob_target(disp_rob_target), .disp_is_c(disp_is_c),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
        .full(full), .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_func3(iss_func3),
        .iss_func1(iss_func1), .iss_data1(iss_data1), .iss_data2(iss_data2),
        .iss_imm(iss_imm), .iss_off(iss_off), .iss_pc(iss_pc),
        .iss_rob_target(iss_rob_target), .iss_is_c(iss_is_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a table of slots, each either empty or holding an op
    // whose operands are known values or outstanding ROB tags.
    typedef struct {
        logic        busy;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f1;
        logic        r1;
        logic [3:0]  q1;
        logic [31:0] v1;
        logic        r2;
        logic [3:0]  q2;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] off;
        logic [31:0] pc;
        logic [3:0]  rob;
        logic        c;
    } m_ent_t;

    m_ent_t      m [16];
    logic        e_valid, e_full, e_f1, e_c;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [31:0] e_d1, e_d2, e_imm, e_off, e_pc;
    logic [3:0]  e_rob;

    int n_tests;
    int n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic resolve(input logic rdy_i, input logic [31:0] val, input logic [3:0] dep,
                           output logic r, output logic [3:0] q, output logic [31:0] v);
        r = 1'b1;
        q = dep;
        v = val;
        if (!rdy_i) begin
            if (alu_cdb_valid && alu_cdb_tag == dep)      v = alu_cdb_data;
            else if (lsb_cdb_valid && lsb_cdb_tag == dep) v = lsb_cdb_data;
            else                                          r = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int sel;
        int slot;
        int cnt;
        if (rst || rollback) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
            e_valid = 0; e_full = 0; e_op = 0; e_f3 = 0; e_f1 = 0; e_d1 = 0; e_d2 = 0;
            e_imm = 0; e_off = 0; e_pc = 0; e_rob = 0; e_c = 0;
            return;
        end
        if (!rdy) return;
        sel = -1;
        for (int i = 0; i < 16; i++)
            if (sel < 0 && m[i].busy && m[i].r1 && m[i].r2) sel = i;
        e_valid = (sel >= 0);
        if (sel >= 0) begin
            e_op = m[sel].op; e_f3 = m[sel].f3; e_f1 = m[sel].f1; e_d1 = m[sel].v1;
            e_d2 = m[sel].v2; e_imm = m[sel].imm; e_off = m[sel].off; e_pc = m[sel].pc;
            e_rob = m[sel].rob; e_c = m[sel].c;
            m[sel].busy = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy && !m[i].r1) resolve(1'b0, m[i].v1, m[i].q1, m[i].r1, m[i].q1, m[i].v1);
            if (m[i].busy && !m[i].r2) resolve(1'b0, m[i].v2, m[i].q2, m[i].r2, m[i].q2, m[i].v2);
        end
        if (disp_valid) begin
            slot = -1;
            for (int i = 0; i < 16; i++)
                if (slot < 0 && !m[i].busy) slot = i;
            if (slot >= 0) begin
                m[slot].busy = 1'b1;
                m[slot].op = disp_opcode; m[slot].f3 = disp_func3; m[slot].f1 = disp_func1;
                m[slot].imm = disp_imm; m[slot].off = disp_off; m[slot].pc = disp_pc;
                m[slot].rob = disp_rob_target; m[slot].c = disp_is_c;
                resolve(disp_rs1_rdy, disp_rs1_val, disp_rs1_dep, m[slot].r1, m[slot].q1, m[slot].v1);
                resolve(disp_rs2_rdy, disp_rs2_val, disp_rs2_dep, m[slot].r2, m[slot].q2, m[slot].v2);
            end
        end
        cnt = 0;
        for (int i = 0; i < 16; i++) if (m[i].busy) cnt++;
        e_full = (cnt >= 15);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_val("iss_valid", {31'd0, iss_valid}, {31'd0, e_valid});
        check_val("full", {31'd0, full}, {31'd0, e_full});
        check_val("iss_data1", iss_data1, e_d1);
        check_val("iss_data2", iss_data2, e_d2);
        check_val("iss_rob", {28'd0, iss_rob_target}, {28'd0, e_rob});
        check_val("iss_opcode", {25'd0, iss_opcode}, {25'd0, e_op});
        check_val("iss_f3_f1_c", {27'd0, iss_func3, iss_func1, iss_is_c}, {27'd0, e_f3, e_f1, e_c});
        check_val("iss_imm", iss_imm, e_imm);
        check_val("iss_off", iss_off, e_off);
        check_val("iss_pc", iss_pc, e_pc);
    endtask

    task automatic idle();
        rst = 0; rdy = 1; rollback = 0;
        disp_valid = 0; alu_cdb_valid = 0; lsb_cdb_valid = 0;
    endtask

    task automatic set_disp(input logic r1, input logic [31:0] v1, input logic [3:0] d1,
                            input logic r2, input logic [31:0] v2, input logic [3:0] d2,
                            input logic [3:0] rob);
        disp_valid = 1;
        disp_opcode = 7'b0110011;
        disp_func3 = 3'($urandom_range(0, 7));
        disp_func1 = 1'($urandom_range(0, 1));
        disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_dep = d1;
        disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_dep = d2;
        disp_imm = $urandom; disp_off = $urandom; disp_pc = $urandom;
        disp_rob_target = rob;
        disp_is_c = 1'($urandom_range(0, 1));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        alu_cdb_tag = 0; alu_cdb_data = 0; lsb_cdb_tag = 0; lsb_cdb_data = 0;

        // Reset held two cycles with a ready op offered: it must never issue.
        rst = 1;
        set_disp(1, 32'd1, 0, 1, 32'd2, 0, 4'd1);
        cycle();
        cycle();
        check_val("rst_full", {31'd0, full}, 0);
        check_val("rst_iss_valid", {31'd0, iss_valid}, 0);
        check_val("rst_iss_data1", iss_data1, 0);
        idle();
        cycle();
        cycle();
        check_val("rst_no_issue", {31'd0, iss_valid}, 0);

        // Fully-ready ADD issues one cycle after its dispatch edge.
        set_disp(1, 32'd5, 0, 1, 32'd7, 0, 4'd3);
        cycle();
        idle();
        cycle();
        check_val("add_valid", {31'd0, iss_valid}, 1);
        check_val("add_data1", iss_data1, 32'd5);
        check_val("add_data2", iss_data2, 32'd7);
        check_val("add_rob", {28'd0, iss_rob_target}, 32'd3);
        cycle();
        check_val("add_pulse", {31'd0, iss_valid}, 0);

        // Pending op1 woken by ALU CDB two cycles after dispatch.
        set_disp(0, 32'd0, 4'd2, 1, 32'd1, 0, 4'd4);
        cycle();
        idle();
        cycle();
        alu_cdb_valid = 1; alu_cdb_tag = 4'd2; alu_cdb_data = 32'h10;
        cycle();
        idle();
        cycle();
        check_val("wake_valid", {31'd0, iss_valid}, 1);
        check_val("wake_data1", iss_data1, 32'h10);

        // CDB broadcast in the dispatch cycle is captured directly.
        set_disp(0, 32'd0, 4'd2, 1, 32'd1, 0, 4'd5);
        alu_cdb_valid = 1; alu_cdb_tag = 4'd2; alu_cdb_data = 32'h10;
        cycle();
        idle();
        cycle();
        check_val("bypass_valid", {31'd0, iss_valid}, 1);
        check_val("bypass_data1", iss_data1, 32'h10);

        // Fill 15 pending entries: full rises; the 16th is still accepted.
        for (int k = 0; k < 15; k++) begin
            set_disp(0, 32'd0, (k == 0) ? 4'd1 : 4'd9, 1, 32'(k), 0, 4'(k));
            cycle();
        end
        check_val("fill_full", {31'd0, full}, 1);
        set_disp(0, 32'd0, 4'd9, 1, 32'd15, 0, 4'd15);
        cycle();
        idle();
        lsb_cdb_valid = 1; lsb_cdb_tag = 4'd1; lsb_cdb_data = 32'hABCD;
        cycle();
        idle();
        cycle();
        check_val("fill_issue0", {31'd0, iss_valid}, 1);
        check_val("fill_rob0", {28'd0, iss_rob_target}, 0);
        lsb_cdb_valid = 1; lsb_cdb_tag = 4'd9; lsb_cdb_data = 32'h99;
        cycle();
        idle();
        for (int k = 0; k < 20; k++) cycle();
        check_val("drain_full", {31'd0, full}, 0);

        // Entries 1 and 4 woken together: lowest index first.
        for (int k = 0; k < 5; k++) begin
            set_disp(0, 32'd0, (k == 1 || k == 4) ? 4'd5 : 4'd12, 1, 32'd0, 0, 4'(k + 2));
            cycle();
        end
        idle();
        alu_cdb_valid = 1; alu_cdb_tag = 4'd5; alu_cdb_data = 32'h55;
        cycle();
        idle();
        cycle();
        check_val("prio_first", {28'd0, iss_rob_target}, 32'd3);
        cycle();
        check_val("prio_second", {28'd0, iss_rob_target}, 32'd6);
        check_val("prio_second_v", {31'd0, iss_valid}, 1);
        rollback = 1;
        cycle();
        idle();

        // Rollback with five pending entries and a ready op about to issue.
        for (int k = 0; k < 5; k++) begin
            set_disp(0, 32'd0, 4'd7, 1, 32'd0, 0, 4'(k));
            cycle();
        end
        set_disp(1, 32'h77, 0, 1, 32'h88, 0, 4'd8);
        cycle();
        idle();
        rollback = 1;
        cycle();
        check_val("rb_iss_valid", {31'd0, iss_valid}, 0);
        check_val("rb_full", {31'd0, full}, 0);
        idle();
        alu_cdb_valid = 1; alu_cdb_tag = 4'd7; alu_cdb_data = 32'h7;
        cycle();
        idle();
        cycle();
        cycle();
        check_val("rb_nothing", {31'd0, iss_valid}, 0);

        // rdy low for three cycles freezes everything, then resumes intact.
        set_disp(1, 32'h123, 0, 1, 32'h456, 0, 4'd11);
        cycle();
        idle();
        rdy = 0;
        set_disp(1, 32'h1, 0, 1, 32'h2, 0, 4'd12);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_val("frz_no_issue", {31'd0, iss_valid}, 0);
        end
        idle();
        cycle();
        check_val("frz_resume", {31'd0, iss_valid}, 1);
        check_val("frz_resume_d1", iss_data1, 32'h123);
        cycle();
        check_val("frz_dropped", {31'd0, iss_valid}, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst      = ($urandom_range(0, 299) == 0);
            rollback = ($urandom_range(0, 149) == 0);
            rdy      = ($urandom_range(0, 9) != 0);
            if (!e_full && $urandom_range(0, 2) != 0)
                set_disp(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)),
                         4'($urandom_range(0, 15)));
            alu_cdb_valid = 1'($urandom_range(0, 1));
            alu_cdb_tag   = 4'($urandom_range(0, 7));
            alu_cdb_data  = $urandom;
            lsb_cdb_valid = 1'($urandom_range(0, 1));
            lsb_cdb_tag   = 4'($urandom_range(0, 7));
            lsb_cdb_data  = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
